// File: rtl/uart_rx_os_if.sv
// Output holding-register handshake between the UART receiver and its consumer.
interface uart_rx_os_if #(
    parameter int unsigned DATA_W = 9
);
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with mid-bit sampling, optional parity,
// 1/2 stop bits, false-start/framing/break detection and a valid/ready output register.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit).
module uart_rx_os #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned LEN_W      = $clog2(DATA_W)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_rst_err,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_stop2,
    input  logic             i_parity,
    input  logic             i_odd,
    input  logic             i_rx,
    uart_rx_os_if.master     rx_out,
    output logic             o_overrun_err,
    output logic             o_parity_err,
    output logic             o_frame_err,
    output logic             o_break,
    output logic             o_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned MID    = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned DEC_TICK = MID + 1;
`else
    localparam int unsigned DEC_TICK = MID;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t            state;
    logic              rx_s1, rx_s2, rx_prev;
    logic [TICK_W-1:0] tick_cnt;
    logic [LEN_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic              all_zero_q, par_bad_q, stop_bad_q, done_q;

    logic              sample_c;
    logic              fall_c;
    logic              dec_c;
    logic              wrap_c;
    logic [LEN_W-1:0]  last_idx_c;

    assign fall_c     = rx_prev & ~rx_s2;
    assign dec_c      = i_ce && (tick_cnt == TICK_W'(DEC_TICK));
    assign wrap_c     = (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign last_idx_c = (i_length >= LEN_W'(DATA_W - 1)) ? LEN_W'(DATA_W - 1) : i_length;

    // Two-flop synchroniser plus tick-rate previous-value flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1 <= i_rx;
            rx_s2 <= rx_s1;
            if (i_ce) rx_prev <= rx_s2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q;

    // Capture the two samples preceding the decision tick for the majority vote.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vote_q <= 2'b11;
        end else if (i_ce) begin
            if (tick_cnt == TICK_W'(MID - 1)) vote_q[0] <= rx_s2;
            if (tick_cnt == TICK_W'(MID))     vote_q[1] <= rx_s2;
        end
    end

    assign sample_c = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s2) | (vote_q[1] & rx_s2);
`else
    assign sample_c = rx_s2;
`endif

    // Frame FSM: tick counting, bit sampling and per-frame error capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            all_zero_q <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            done_q     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_ce) begin
                if (state != S_IDLE) tick_cnt <= wrap_c ? '0 : tick_cnt + TICK_W'(1);
                case (state)
                    S_IDLE: begin
                        if (fall_c) begin
                            state    <= S_START;
                            tick_cnt <= TICK_W'(1);
                            o_busy   <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (dec_c) begin
                            if (sample_c) begin
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                state      <= S_DATA;
                                bit_cnt    <= '0;
                                shift_q    <= '0;
                                all_zero_q <= 1'b1;
                                par_bad_q  <= 1'b0;
                                stop_bad_q <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (dec_c) begin
                            shift_q[bit_cnt] <= sample_c;
                            if (sample_c) all_zero_q <= 1'b0;
                            if (bit_cnt == last_idx_c) state <= i_parity ? S_PARITY : S_STOP1;
                            else bit_cnt <= bit_cnt + LEN_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (dec_c) begin
                            par_bad_q <= (^shift_q) ^ sample_c ^ i_odd;
                            if (sample_c) all_zero_q <= 1'b0;
                            state <= S_STOP1;
                        end
                    end
                    S_STOP1, S_STOP2: begin
                        if (dec_c) begin
                            if (sample_c) all_zero_q <= 1'b0;
                            else stop_bad_q <= 1'b1;
                            if (state == S_STOP1 && i_stop2) begin
                                state <= S_STOP2;
                            end else begin
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic set_ovr_c, set_par_c, set_frm_c, set_brk_c;

    assign set_ovr_c = done_q && rx_out.o_valid && !rx_out.i_ready;
    assign set_par_c = done_q && par_bad_q;
    assign set_frm_c = done_q && stop_bad_q;
    assign set_brk_c = done_q && all_zero_q;

    // Output holding register: load on completion unless an unconsumed frame blocks it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_out.o_data  <= '0;
            rx_out.o_valid <= 1'b0;
        end else if (done_q && (!rx_out.o_valid || rx_out.i_ready)) begin
            rx_out.o_data  <= shift_q;
            rx_out.o_valid <= 1'b1;
        end else if (rx_out.o_valid && rx_out.i_ready) begin
            rx_out.o_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same cycle wins over i_rst_err.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun_err <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_break       <= 1'b0;
        end else begin
            o_overrun_err <= set_ovr_c | (o_overrun_err & ~i_rst_err);
            o_parity_err  <= set_par_c | (o_parity_err  & ~i_rst_err);
            o_frame_err   <= set_frm_c | (o_frame_err   & ~i_rst_err);
            o_break       <= set_brk_c | (o_break       & ~i_rst_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: stimulus pushes expected words, monitor pops on handshake.
module tb_uart_rx_os;

    localparam int unsigned DATA_W     = 9;
    localparam int unsigned OVERSAMPLE = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_MAX = 81;
`else
    localparam int LAT_MAX = 80;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_ce = 1'b1;
    logic       i_rst_err = 1'b0;
    logic [3:0] i_length = 4'd7;
    logic       i_stop2 = 1'b0;
    logic       i_parity = 1'b0;
    logic       i_odd = 1'b0;
    logic       i_rx = 1'b1;
    logic       o_overrun_err, o_parity_err, o_frame_err, o_break, o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pop_cyc = 0;
    logic [DATA_W-1:0] exp_q[$];

    uart_rx_os_if #(.DATA_W(DATA_W)) rx_if ();

    uart_rx_os #(.DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ce          (i_ce),
        .i_rst_err     (i_rst_err),
        .i_length      (i_length),
        .i_stop2       (i_stop2),
        .i_parity      (i_parity),
        .i_odd         (i_odd),
        .i_rx          (i_rx),
        .rx_out        (rx_if.master),
        .o_overrun_err (o_overrun_err),
        .o_parity_err  (o_parity_err),
        .o_frame_err   (o_frame_err),
        .o_break       (o_break),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected word.
    always @(negedge i_clk) begin
        if (rx_if.o_valid && rx_if.i_ready) begin
            pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(rx_if.o_data), 32'hFFFF_FFFF);
            end else begin
                check("word", 32'(rx_if.o_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic bit_out(input logic v, input logic glitch);
        for (int i = 0; i < int'(OVERSAMPLE); i++) begin
            @(negedge i_clk);
            if (i == 0) start_cyc = cyc;
            i_rx = (glitch && i == int'(OVERSAMPLE / 2)) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop2, input int glitch_idx);
        int t0;
        bit_out(1'b0, 1'b0);
        t0 = start_cyc;
        for (int i = 0; i < nbits; i++) bit_out(d[i], i == glitch_idx);
        if (par_en) bit_out(par_bit, 1'b0);
        bit_out(1'b1, 1'b0);
        if (stop2) bit_out(1'b1, 1'b0);
        start_cyc = t0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        if (o_busy) check("busy_timeout", 32'(o_busy), 32'd0);
        idle(4);
    endtask

    task automatic pulse_rst_err();
        @(negedge i_clk) i_rst_err = 1'b1;
        @(negedge i_clk) i_rst_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.i_ready = 1'b1;
        idle(3);
        check("rst_valid", 32'(rx_if.o_valid), 32'd0);
        check("rst_data", 32'(rx_if.o_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ovr", 32'(o_overrun_err), 32'd0);
        check("rst_par", 32'(o_parity_err), 32'd0);
        check("rst_frm_brk", 32'({o_frame_err, o_break}), 32'd0);
        i_rst_n = 1'b1;
        idle(10);

        // 8N1 0xA5
        exp_q.push_back(9'h0A5);
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, -1);
        wait_idle();
        check("a5_latency_ok", 32'((pop_cyc - start_cyc) <= LAT_MAX && pop_cyc > start_cyc), 32'd1);
        check("a5_flags", 32'({o_overrun_err, o_parity_err, o_frame_err, o_break}), 32'd0);
        check("a5_busy", 32'(o_busy), 32'd0);
        check("a5_valid_consumed", 32'(rx_if.o_valid), 32'd0);

        // 7E1 0x55 with wrong parity bit 1
        i_length = 4'd6; i_parity = 1'b1; i_odd = 1'b0;
        exp_q.push_back(9'h055);
        send_frame(9'h055, 7, 1'b1, 1'b1, 1'b0, -1);
        wait_idle();
        check("7e1_par_err", 32'(o_parity_err), 32'd1);
        check("7e1_frm_err", 32'({o_frame_err, o_break, o_overrun_err}), 32'd0);
        pulse_rst_err();
        idle(1);
        check("7e1_par_cleared", 32'(o_parity_err), 32'd0);

        // 7O1 0x55 with correct odd parity bit 1: no error
        i_odd = 1'b1;
        exp_q.push_back(9'h055);
        send_frame(9'h055, 7, 1'b1, 1'b1, 1'b0, -1);
        wait_idle();
        check("7o1_par_ok", 32'(o_parity_err), 32'd0);
        i_length = 4'd7; i_parity = 1'b0; i_odd = 1'b0;
        idle(10);

        // False start: two low cycles
        @(negedge i_clk) i_rx = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk) i_rx = 1'b1;
        @(negedge i_clk);
        check("fs_busy_high", 32'(o_busy), 32'd1);
        idle(20);
        check("fs_busy_low", 32'(o_busy), 32'd0);
        check("fs_no_valid", 32'(rx_if.o_valid), 32'd0);
        check("fs_flags", 32'({o_overrun_err, o_parity_err, o_frame_err, o_break}), 32'd0);

        // Overrun: two frames with consumer stalled
        @(negedge i_clk) rx_if.i_ready = 1'b0;
        exp_q.push_back(9'h011);
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, -1);
        wait_idle();
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, -1);
        wait_idle();
        check("ovr_data", 32'(rx_if.o_data), 32'h011);
        check("ovr_valid", 32'(rx_if.o_valid), 32'd1);
        check("ovr_flag", 32'(o_overrun_err), 32'd1);
        @(posedge i_clk); #1 rx_if.i_ready = 1'b1;
        @(posedge i_clk); #1 rx_if.i_ready = 1'b0;
        @(negedge i_clk);
        check("ovr_valid_cleared", 32'(rx_if.o_valid), 32'd0);
        rx_if.i_ready = 1'b1;
        pulse_rst_err();
        idle(1);
        check("ovr_flag_cleared", 32'(o_overrun_err), 32'd0);

        // Break, 8N2: line low 200 cycles
        i_stop2 = 1'b1;
        exp_q.push_back(9'h000);
        @(negedge i_clk) i_rx = 1'b0;
        idle(199);
        check("brk_busy_low", 32'(o_busy), 32'd0);
        check("brk_frame_err", 32'(o_frame_err), 32'd1);
        check("brk_break", 32'(o_break), 32'd1);
        check("brk_par_ovr", 32'({o_parity_err, o_overrun_err}), 32'd0);
        i_rx = 1'b1;
        idle(20);
        pulse_rst_err();
        idle(1);
        check("brk_cleared", 32'({o_frame_err, o_break}), 32'd0);

        // 0x3C 8N2, held unconsumed for the reset test
        rx_if.i_ready = 1'b0;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, -1);
        wait_idle();
        check("3c_data", 32'(rx_if.o_data), 32'h03C);
        check("3c_valid", 32'(rx_if.o_valid), 32'd1);
        check("3c_flags", 32'({o_overrun_err, o_parity_err, o_frame_err, o_break}), 32'd0);
        i_stop2 = 1'b0;

        // Reset in the middle of the data bits
        bit_out(1'b0, 1'b0);
        bit_out(1'b1, 1'b0);
        bit_out(1'b1, 1'b0);
        bit_out(1'b0, 1'b0);
        check("mid_busy_before", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_valid", 32'(rx_if.o_valid), 32'd0);
        check("mid_rst_data", 32'(rx_if.o_data), 32'd0);
        i_rx = 1'b1;
        idle(5);
        i_rst_n = 1'b1;
        rx_if.i_ready = 1'b1;
        idle(20);
        check("post_rst_no_valid", 32'(rx_if.o_valid), 32'd0);

        exp_q.push_back(9'h0C3);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, -1);
        wait_idle();
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(9'h0C3);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 2);
        wait_idle();
`endif
        check("c3_flags", 32'({o_overrun_err, o_parity_err, o_frame_err, o_break}), 32'd0);
        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
